// File: rtl/reg_write_arbiter_if.sv
// Bundle for the two-requester register-write arbiter: requester
// handshakes, the hold input, both register-file write ports and the
// conflict counter. master = requester/host side, slave = arbiter.
interface reg_write_arbiter_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   localparam int NREG = 1 << AW;

   logic            hold;
   logic            a_valid;
   logic [AW-1:0]   a_addr;
   logic [DW-1:0]   a_data;
   logic            a_ready;
   logic            b_valid;
   logic [AW-1:0]   b_addr;
   logic [DW-1:0]   b_data;
   logic            b_ready;
   logic [NREG-1:0] wr0_en;
   logic [DW-1:0]   wr0_data;
   logic [NREG-1:0] wr1_en;
   logic [DW-1:0]   wr1_data;
   logic [7:0]      conflict_cnt;

   modport master (
      output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, wr0_en, wr0_data, wr1_en, wr1_data, conflict_cnt
   );

   modport slave (
      input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, wr0_en, wr0_data, wr1_en, wr1_data, conflict_cnt
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester register-write arbiter. A normally drives write port 0 and
// B drives write port 1; when both target the same register only one is
// granted (round-robin via prio) and the winner goes out on port 0, so the
// two ports can never strobe the same register in one cycle. Writes appear
// registered one cycle after acceptance.
module reg_write_arbiter #(
   parameter int DW = 16,
   parameter int AW = 3
) (
   input logic              Clk,
   input logic              Rst,
   reg_write_arbiter_if.slave bus
);
   localparam int NREG = 1 << AW;

   logic          prio;      // 0: A wins the next conflict, 1: B wins
   logic          conflict;
   logic          a_go, b_go;
   logic          p0_go, p1_go;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_data, p1_data;

   // Grant decision and port routing for the current cycle
   always_comb begin
      conflict = bus.a_valid & bus.b_valid & (bus.a_addr == bus.b_addr) & ~bus.hold;
      // Reset gates the readies so nothing pending during reset is accepted
      a_go = ~Rst & ~bus.hold & bus.a_valid & (~conflict | ~prio);
      b_go = ~Rst & ~bus.hold & bus.b_valid & (~conflict | prio);
      // Port 0 carries A, or B when B wins a conflict
      p0_go   = a_go | (conflict & b_go);
      p0_addr = a_go ? bus.a_addr : bus.b_addr;
      p0_data = a_go ? bus.a_data : bus.b_data;
      // Port 1 only ever carries a non-conflicting B
      p1_go   = b_go & ~conflict;
      p1_addr = bus.b_addr;
      p1_data = bus.b_data;
   end

   assign bus.a_ready = a_go;
   assign bus.b_ready = b_go;

   // Registered write ports: one-hot strobe for one cycle, data held when idle
   always_ff @(posedge Clk) begin
      if (Rst) begin
         bus.wr0_en   <= '0;
         bus.wr0_data <= '0;
         bus.wr1_en   <= '0;
         bus.wr1_data <= '0;
      end else begin
         bus.wr0_en <= p0_go ? (NREG'(1) << p0_addr) : '0;
         bus.wr1_en <= p1_go ? (NREG'(1) << p1_addr) : '0;
         if (p0_go) bus.wr0_data <= p0_data;
         if (p1_go) bus.wr1_data <= p1_data;
      end
   end

   // Round-robin pointer: hand priority to the loser after each conflict grant
   always_ff @(posedge Clk) begin
      if (Rst)           prio <= 1'b0;
      else if (conflict) prio <= ~prio;
   end

   // Saturating conflict counter
   always_ff @(posedge Clk) begin
      if (Rst)
         bus.conflict_cnt <= '0;
      else if (conflict && bus.conflict_cnt != 8'hFF)
         bus.conflict_cnt <= bus.conflict_cnt + 8'd1;
   end
endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   reg_write_arbiter_if #(.DW(16), .AW(3)) bus ();
   reg_write_arbiter #(.DW(16), .AW(3)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   always #5 Clk = ~Clk;

   // advance to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic h, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                        input logic bv, input logic [2:0] ba, input logic [15:0] bd);
      bus.hold = h;
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc();
      Rst = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      drive(0, 1, 3'd2, 16'h1111, 1, 3'd5, 16'h2222);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready got=%b exp=00", {bus.a_ready, bus.b_ready}); end
      cyc();
      checks++; if ({bus.wr0_en, bus.wr1_en, bus.wr0_data, bus.wr1_data, bus.conflict_cnt} !== 56'd0) begin
         errors++; $display("FAIL reset_outputs got en0=%h en1=%h d0=%h d1=%h cnt=%0d exp all 0",
                           bus.wr0_en, bus.wr1_en, bus.wr0_data, bus.wr1_data, bus.conflict_cnt); end
      drive(0, 0, 0, 0, 0, 0, 0);
      cyc();
      checks++; if ({bus.wr0_en, bus.wr1_en} !== 16'd0) begin
         errors++; $display("FAIL reset_no_write got en0=%h en1=%h exp 0", bus.wr0_en, bus.wr1_en); end
      Rst = 1'b0;
   endtask

   task automatic test_no_conflict();
      do_reset();
      drive(0, 1, 3'd2, 16'h1234, 1, 3'd5, 16'hBEEF);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b11) begin
         errors++; $display("FAIL nc_ready got=%b exp=11", {bus.a_ready, bus.b_ready}); end
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.wr0_en !== 8'h04 || bus.wr0_data !== 16'h1234) begin
         errors++; $display("FAIL nc_port0 got en=%h d=%h exp en=04 d=1234", bus.wr0_en, bus.wr0_data); end
      checks++; if (bus.wr1_en !== 8'h20 || bus.wr1_data !== 16'hBEEF) begin
         errors++; $display("FAIL nc_port1 got en=%h d=%h exp en=20 d=beef", bus.wr1_en, bus.wr1_data); end
      checks++; if (bus.conflict_cnt !== 8'd0) begin
         errors++; $display("FAIL nc_cnt got=%0d exp=0", bus.conflict_cnt); end
      cyc();
      // idle: enables clear, data held
      checks++; if (bus.wr0_en !== 8'h00 || bus.wr1_en !== 8'h00 || bus.wr0_data !== 16'h1234 || bus.wr1_data !== 16'hBEEF) begin
         errors++; $display("FAIL nc_idle got en0=%h en1=%h d0=%h d1=%h exp 00 00 1234 beef",
                           bus.wr0_en, bus.wr1_en, bus.wr0_data, bus.wr1_data); end
      // A only: ready must follow valid, B not ready
      drive(0, 1, 3'd7, 16'h0F0F, 0, 3'd7, 16'hFFFF);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
         errors++; $display("FAIL nc_aonly_ready got=%b exp=10", {bus.a_ready, bus.b_ready}); end
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.wr0_en !== 8'h80 || bus.wr1_en !== 8'h00 || bus.wr0_data !== 16'h0F0F) begin
         errors++; $display("FAIL nc_aonly_write got en0=%h en1=%h d0=%h exp 80 00 0f0f", bus.wr0_en, bus.wr1_en, bus.wr0_data); end
   endtask

   task automatic test_conflict_pair();
      do_reset();
      drive(0, 1, 3'd3, 16'hAAAA, 1, 3'd3, 16'h5555);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
         errors++; $display("FAIL cp1_ready got=%b exp=10", {bus.a_ready, bus.b_ready}); end
      cyc();
      checks++; if (bus.wr0_en !== 8'h08 || bus.wr0_data !== 16'hAAAA || bus.wr1_en !== 8'h00 || bus.conflict_cnt !== 8'd1) begin
         errors++; $display("FAIL cp1_write got en0=%h d0=%h en1=%h cnt=%0d exp 08 aaaa 00 1",
                           bus.wr0_en, bus.wr0_data, bus.wr1_en, bus.conflict_cnt); end
      // A re-presents a new request to the same register; B must win now
      drive(0, 1, 3'd3, 16'hAAAA, 1, 3'd3, 16'h5555);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
         errors++; $display("FAIL cp2_ready got=%b exp=01", {bus.a_ready, bus.b_ready}); end
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.wr0_en !== 8'h08 || bus.wr0_data !== 16'h5555 || bus.wr1_en !== 8'h00 || bus.conflict_cnt !== 8'd2) begin
         errors++; $display("FAIL cp2_write got en0=%h d0=%h en1=%h cnt=%0d exp 08 5555 00 2",
                           bus.wr0_en, bus.wr0_data, bus.wr1_en, bus.conflict_cnt); end
   endtask

   task automatic test_alternate();
      logic [1:0]  exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
      logic [15:0] exp_dat [4] = '{16'h1000, 16'h2001, 16'h1002, 16'h2003};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 3'd6, 16'h1000 + 16'(i), 1, 3'd6, 16'h2000 + 16'(i));
         checks++; if ({bus.a_ready, bus.b_ready} !== exp_rdy[i]) begin
            errors++; $display("FAIL alt_ready[%0d] got=%b exp=%b", i, {bus.a_ready, bus.b_ready}, exp_rdy[i]); end
         cyc();
         checks++; if (bus.wr0_en !== 8'h40 || bus.wr0_data !== exp_dat[i] || bus.wr1_en !== 8'h00) begin
            errors++; $display("FAIL alt_write[%0d] got en0=%h d0=%h en1=%h exp 40 %h 00",
                              i, bus.wr0_en, bus.wr0_data, bus.wr1_en, exp_dat[i]); end
      end
      checks++; if (bus.conflict_cnt !== 8'd4) begin
         errors++; $display("FAIL alt_cnt got=%0d exp=4", bus.conflict_cnt); end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_hold();
      do_reset();
      drive(0, 1, 3'd1, 16'hA001, 1, 3'd1, 16'hB001);  // A wins, prio -> B
      cyc();
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 3'd1, 16'hA002, 1, 3'd1, 16'hB002);
         checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
            errors++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {bus.a_ready, bus.b_ready}); end
         cyc();
         checks++; if (bus.wr0_en !== 8'h00 || bus.wr1_en !== 8'h00 || bus.conflict_cnt !== 8'd1) begin
            errors++; $display("FAIL hold_out[%0d] got en0=%h en1=%h cnt=%0d exp 00 00 1",
                              i, bus.wr0_en, bus.wr1_en, bus.conflict_cnt); end
      end
      drive(0, 1, 3'd1, 16'hA002, 1, 3'd1, 16'hB002);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b01) begin
         errors++; $display("FAIL hold_release_ready got=%b exp=01", {bus.a_ready, bus.b_ready}); end
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.wr0_en !== 8'h02 || bus.wr0_data !== 16'hB002 || bus.conflict_cnt !== 8'd2) begin
         errors++; $display("FAIL hold_release_write got en0=%h d0=%h cnt=%0d exp 02 b002 2",
                           bus.wr0_en, bus.wr0_data, bus.conflict_cnt); end
   endtask

   task automatic test_saturate();
      do_reset();
      drive(0, 1, 3'd4, 16'h0001, 1, 3'd4, 16'h0002);
      for (int i = 0; i < 255; i++) cyc();
      checks++; if (bus.conflict_cnt !== 8'd255) begin
         errors++; $display("FAIL sat_255 got=%0d exp=255", bus.conflict_cnt); end
      for (int i = 0; i < 45; i++) cyc();
      checks++; if (bus.conflict_cnt !== 8'd255) begin
         errors++; $display("FAIL sat_300 got=%0d exp=255", bus.conflict_cnt); end
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive(0, 1, 3'd0, 16'hC0DE, 1, 3'd0, 16'hD00D);  // A wins, prio -> B, cnt 1
      cyc();
      Rst = 1'b1;
      drive(0, 1, 3'd0, 16'hC0DE, 1, 3'd2, 16'hD00D);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin
         errors++; $display("FAIL mr_ready got=%b exp=00", {bus.a_ready, bus.b_ready}); end
      cyc();
      Rst = 1'b0;
      checks++; if ({bus.wr0_en, bus.wr1_en} !== 16'd0 || bus.conflict_cnt !== 8'd0) begin
         errors++; $display("FAIL mr_out got en0=%h en1=%h cnt=%0d exp 00 00 0", bus.wr0_en, bus.wr1_en, bus.conflict_cnt); end
      // prio back at A
      drive(0, 1, 3'd0, 16'hC0DE, 1, 3'd0, 16'hD00D);
      checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin
         errors++; $display("FAIL mr_prio got=%b exp=10", {bus.a_ready, bus.b_ready}); end
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.wr0_en !== 8'h01 || bus.wr0_data !== 16'hC0DE || bus.conflict_cnt !== 8'd1) begin
         errors++; $display("FAIL mr_write got en0=%h d0=%h cnt=%0d exp 01 c0de 1", bus.wr0_en, bus.wr0_data, bus.conflict_cnt); end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_no_conflict();
      test_conflict_pair();
      test_alternate();
      test_hold();
      test_saturate();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
